// File: rtl/axi4_video_frame_checker_pkg.sv
// Package for the video frame checker: FSM state encoding, error-vector
// bit positions, counter widths and the ramp-pattern compare helper.
package axi4_video_chk_pkg;

  // Frame-tracking FSM states
  typedef enum logic [1:0] {
    WAIT_SOF   = 2'd0,
    ACTIVE     = 2'd1,
    EXPECT_SOF = 2'd2
  } chk_state_e;

  // Bit positions inside the per-beat error vector
  typedef enum logic [2:0] {
    SOF_EARLY   = 3'd0,
    SOF_MISSING = 3'd1,
    EOL_EARLY   = 3'd2,
    EOL_LATE    = 3'd3,
    DATA        = 3'd4
  } err_idx_e;

  localparam int ERR_NUM       = 5;
  localparam int ERR_CNT_WIDTH = 16;

  // The ramp source replicates px[9:0] into three 10-bit lanes.
  function automatic logic ramp_mismatch(input logic [29:0] data,
                                         input logic [9:0]  px);
    return (data[9:0] != px) || (data[19:10] != px) || (data[29:20] != px);
  endfunction

  // Saturating increment for the error counter
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
      input logic [ERR_CNT_WIDTH-1:0] val);
    if (val == {ERR_CNT_WIDTH{1'b1}}) begin
      return val;
    end else begin
      return val + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/axi4_video_frame_checker_if.sv
// AXI4-Stream video interface (tvalid/tready/tdata/tlast/tuser).
// master: drives data and framing, receives tready.
// slave : receives data and framing, drives tready.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axi4_video_frame_checker_pos_cnt.sv
// Pixel/line position counters for the frame checker.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   beat_i              advance the position by one accepted beat
//   force_line_end_i    end the line on this beat regardless of px
//   force_origin_i      this beat is pixel (0,0)
//   px_o, ln_o          position of the beat presented this cycle
//   line_end_o          this beat terminates a line
//   frame_end_o         this beat terminates the last line of a frame
module axi4_video_pos_cnt #(
  parameter int X_ACTIVE = 1920,
  parameter int Y_ACTIVE = 1080,
  parameter int PX_W     = 11,
  parameter int LN_W     = 11
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            beat_i,
  input  logic            force_line_end_i,
  input  logic            force_origin_i,
  output logic [PX_W-1:0] px_o,
  output logic [LN_W-1:0] ln_o,
  output logic            line_end_o,
  output logic            frame_end_o
);

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(X_ACTIVE - 1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(Y_ACTIVE - 1);

  logic [PX_W-1:0] r_px;
  logic [LN_W-1:0] r_ln;
  logic [PX_W-1:0] w_px;
  logic [LN_W-1:0] w_ln;
  logic            w_line_end;
  logic            w_frame_end;

  // Effective position of the current beat; an origin beat restarts at (0,0)
  always_comb begin
    if (force_origin_i) begin
      w_px = '0;
      w_ln = '0;
    end else begin
      w_px = r_px;
      w_ln = r_ln;
    end
    w_line_end  = force_line_end_i || (w_px == PX_LAST);
    w_frame_end = w_line_end && (w_ln == LN_LAST);
  end

  // Position registers advance only on accepted beats
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_px <= '0;
      r_ln <= '0;
    end else if (beat_i) begin
      if (w_line_end) begin
        r_px <= '0;
        r_ln <= w_frame_end ? '0 : (w_ln + LN_W'(1));
      end else begin
        r_px <= w_px + PX_W'(1);
        r_ln <= w_ln;
      end
    end else begin
      r_px <= r_px;
      r_ln <= r_ln;
    end
  end

  assign px_o        = w_px;
  assign ln_o        = w_ln;
  assign line_end_o  = w_line_end;
  assign frame_end_o = w_frame_end;

endmodule

// File: rtl/axi4_video_frame_checker.sv
// AXI4-Stream video sink that checks tuser/tlast framing and the ramp data
// pattern, and reports sticky errors, an error count and frame geometry.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   video_i               AXI4-Stream slave (tready is driven here)
//   rx_en_i               enables tready (one-cycle latency)
//   clear_i               clears sticky errors, err_cnt_o and locked_o
//   err_*_o               sticky framing / data error flags
//   err_cnt_o             saturating count of beats with any error
//   line_len_o            pixel count of the last tlast-terminated line
//   frame_cnt_o           completed frames (wraps)
//   frame_done_o          one-cycle pulse per completed frame
//   locked_o              last complete frame was error-free
module axi4_video_frame_checker
  import axi4_video_chk_pkg::*;
#(
  parameter int Y_ACTIVE    = 1080,
  parameter int X_ACTIVE    = 1920,
  parameter int TDATA_WIDTH = 32,
  parameter int CHECK_DATA  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  axi4_stream_if.slave                  video_i,
  input  logic                          rx_en_i,
  input  logic                          clear_i,
  output logic                          err_sof_early_o,
  output logic                          err_sof_missing_o,
  output logic                          err_eol_early_o,
  output logic                          err_eol_late_o,
  output logic                          err_data_o,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o,
  output logic [$clog2(X_ACTIVE+1)-1:0] line_len_o,
  output logic [31:0]                   frame_cnt_o,
  output logic                          frame_done_o,
  output logic                          locked_o
);

  localparam int PX_W = (X_ACTIVE > 1) ? $clog2(X_ACTIVE) : 1;
  localparam int LN_W = (Y_ACTIVE > 1) ? $clog2(Y_ACTIVE) : 1;
  localparam int LL_W = $clog2(X_ACTIVE + 1);

  localparam logic [1:0] S_WAIT_SOF   = 2'(WAIT_SOF);
  localparam logic [1:0] S_ACTIVE     = 2'(ACTIVE);
  localparam logic [1:0] S_EXPECT_SOF = 2'(EXPECT_SOF);

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(X_ACTIVE - 1);

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic                     r_tready;
  logic [ERR_NUM-1:0]       r_err_flags;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [LL_W-1:0]          r_line_len;
  logic [31:0]              r_frame_cnt;
  logic                     r_frame_done;
  logic                     r_locked;
  logic                     r_frame_err;

  logic                     w_beat;
  logic                     w_tuser;
  logic                     w_tlast;
  logic                     w_origin;
  logic                     w_cnt_en;
  logic [PX_W-1:0]          w_px;
  logic [LN_W-1:0]          w_ln;
  logic                     w_line_end;
  logic                     w_frame_end;
  logic                     w_frame_done;
  logic [ERR_NUM-1:0]       w_pix_err;
  logic [ERR_NUM-1:0]       w_err;
  logic [ERR_NUM-1:0]       w_err_frame;
  logic                     w_any_err;
  logic                     w_frame_err_now;

  assign w_beat   = video_i.tvalid & r_tready;
  assign w_tuser  = video_i.tuser;
  assign w_tlast  = video_i.tlast;
  // Any tuser beat restarts the position at (0,0), whatever the state
  assign w_origin = w_beat & w_tuser;
  // Beats outside a frame (no tuser while waiting) do not move the counters
  assign w_cnt_en = w_beat & ((r_state == S_ACTIVE) | w_tuser);

  axi4_video_pos_cnt #(
    .X_ACTIVE (X_ACTIVE),
    .Y_ACTIVE (Y_ACTIVE),
    .PX_W     (PX_W),
    .LN_W     (LN_W)
  ) u_pos_cnt (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .beat_i           (w_cnt_en),
    .force_line_end_i (w_tlast),
    .force_origin_i   (w_origin),
    .px_o             (w_px),
    .ln_o             (w_ln),
    .line_end_o       (w_line_end),
    .frame_end_o      (w_frame_end)
  );

  assign w_frame_done = w_cnt_en & w_frame_end;

  // Per-beat error vector for the beat presented this cycle
  always_comb begin
    w_pix_err            = '0;
    w_pix_err[EOL_EARLY] = w_tlast && (w_px != PX_LAST);
    w_pix_err[EOL_LATE]  = !w_tlast && (w_px == PX_LAST);
    w_pix_err[DATA]      = (CHECK_DATA != 0) &&
                           ramp_mismatch(video_i.tdata[29:0], 10'(w_px));
    w_err = '0;
    if (w_beat) begin
      case (r_state)
        S_WAIT_SOF: begin
          if (w_tuser) begin
            w_err = w_pix_err;
          end else begin
            w_err = '0;
          end
        end
        S_ACTIVE: begin
          w_err            = w_pix_err;
          w_err[SOF_EARLY] = w_tuser;
        end
        S_EXPECT_SOF: begin
          if (w_tuser) begin
            w_err = w_pix_err;
          end else begin
            w_err[SOF_MISSING] = 1'b1;
          end
        end
        default: begin
          w_err = '0;
        end
      endcase
    end else begin
      w_err = '0;
    end
  end

  assign w_any_err = |w_err;

  // An early SOF belongs to the abandoned frame, not to the one it starts
  always_comb begin
    w_err_frame            = w_err;
    w_err_frame[SOF_EARLY] = 1'b0;
    if (w_origin) begin
      w_frame_err_now = 1'b0;
    end else begin
      w_frame_err_now = r_frame_err;
    end
  end

  // Next-state selection for the frame-tracking FSM
  always_comb begin
    if (w_cnt_en && w_frame_end) begin
      w_state_nxt = S_EXPECT_SOF;
    end else if (w_cnt_en) begin
      w_state_nxt = S_ACTIVE;
    end else if (w_beat && (r_state == S_EXPECT_SOF)) begin
      w_state_nxt = S_WAIT_SOF;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state and tready registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_WAIT_SOF;
      r_tready <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tready <= rx_en_i;
    end
  end

  // Sticky error flags and saturating error counter; a new error beats clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_flags <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_flags <= (clear_i ? '0 : r_err_flags) | w_err;
      if (clear_i && w_any_err) begin
        r_err_cnt <= ERR_CNT_WIDTH'(1);
      end else if (clear_i) begin
        r_err_cnt <= '0;
      end else if (w_any_err) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  // Geometry, frame counting and lock status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_line_len   <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      if (w_cnt_en && w_tlast) begin
        r_line_len <= LL_W'(w_px) + LL_W'(1);
      end else begin
        r_line_len <= r_line_len;
      end

      r_frame_done <= w_frame_done;
      r_frame_cnt  <= r_frame_cnt + (w_frame_done ? 32'd1 : 32'd0);

      if (w_origin) begin
        r_frame_err <= |w_err_frame;
      end else if (w_any_err) begin
        r_frame_err <= 1'b1;
      end else begin
        r_frame_err <= r_frame_err;
      end

      if (w_any_err) begin
        r_locked <= 1'b0;
      end else if (w_frame_done) begin
        r_locked <= !w_frame_err_now;
      end else if (clear_i) begin
        r_locked <= 1'b0;
      end else begin
        r_locked <= r_locked;
      end
    end
  end

  assign video_i.tready    = r_tready;
  assign err_sof_early_o   = r_err_flags[SOF_EARLY];
  assign err_sof_missing_o = r_err_flags[SOF_MISSING];
  assign err_eol_early_o   = r_err_flags[EOL_EARLY];
  assign err_eol_late_o    = r_err_flags[EOL_LATE];
  assign err_data_o        = r_err_flags[DATA];
  assign err_cnt_o         = r_err_cnt;
  assign line_len_o        = r_line_len;
  assign frame_cnt_o       = r_frame_cnt;
  assign frame_done_o      = r_frame_done;
  assign locked_o          = r_locked;

endmodule

// File: tb/tb_axi4_video_frame_checker.sv
// Scoreboard bench for axi4_video_frame_checker with an 8x4 frame geometry.
// Frame-completion expectations are queued by the stimulus and consumed by
// a monitor on every frame_done pulse; status flags are checked directly.
module tb_axi4_video_frame_checker;

  localparam int X   = 8;
  localparam int Y   = 4;
  localparam int TW  = 32;
  localparam int LLW = $clog2(X + 1);

  typedef struct {
    int fcnt;
    bit locked;
    int llen;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_en;
  logic clear;

  logic            err_sof_early, err_sof_missing, err_eol_early;
  logic            err_eol_late, err_data, frame_done, locked;
  logic [15:0]     err_cnt;
  logic [LLW-1:0]  line_len;
  logic [31:0]     frame_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_frames = 0;
  bit   tog_en = 1'b0;
  int   tog_cnt = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(TW)) vid ();

  axi4_video_frame_checker #(
    .Y_ACTIVE    (Y),
    .X_ACTIVE    (X),
    .TDATA_WIDTH (TW),
    .CHECK_DATA  (1)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .video_i           (vid),
    .rx_en_i           (rx_en),
    .clear_i           (clear),
    .err_sof_early_o   (err_sof_early),
    .err_sof_missing_o (err_sof_missing),
    .err_eol_early_o   (err_eol_early),
    .err_eol_late_o    (err_eol_late),
    .err_data_o        (err_data),
    .err_cnt_o         (err_cnt),
    .line_len_o        (line_len),
    .frame_cnt_o       (frame_cnt),
    .frame_done_o      (frame_done),
    .locked_o          (locked)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ramp(input int px);
    logic [9:0] p;
    p = 10'(px);
    return {2'b00, p, p, p};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted; clr rides along with it
  task automatic send_beat(input logic [31:0] d, input logic l, input logic u,
                           input logic clr);
    int guard;
    guard = 0;
    vid.tvalid = 1'b1;
    vid.tdata  = d;
    vid.tlast  = l;
    vid.tuser  = u;
    while (!vid.tready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!vid.tready) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: tready got=0 required=1");
    end
    clear = clr;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    vid.tvalid = 1'b0;
    vid.tlast  = 1'b0;
    vid.tuser  = 1'b0;
  endtask

  task automatic send_pix(input int px, input logic u, input logic l,
                          input logic [31:0] corrupt, input logic clr);
    send_beat(ramp(px) ^ corrupt, l, u, clr);
  endtask

  task automatic send_clean_frame(input bit gaps);
    for (int ln = 0; ln < Y; ln++) begin
      for (int px = 0; px < X; px++) begin
        send_pix(px, (ln == 0) && (px == 0), px == X - 1, 32'h0, 1'b0);
        if (gaps && (((ln * X + px) % 3) == 1)) idle(1 + (px % 2));
      end
    end
  endtask

  task automatic expect_frame(input bit lk);
    exp_t e;
    exp_frames++;
    e.fcnt   = exp_frames;
    e.locked = lk;
    e.llen   = X;
    q.push_back(e);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    idle(1);
  endtask

  // Monitor: every frame_done pulse must match the next queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && frame_done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame_done: got frame_cnt=%0d required=no pulse", frame_cnt);
        end else begin
          mon_e = q.pop_front();
          chk("frame_cnt_at_done", frame_cnt, mon_e.fcnt);
          chk("locked_at_done", 32'(locked), 32'(mon_e.locked));
          chk("line_len_at_done", 32'(line_len), mon_e.llen);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    rx_en      = 1'b0;
    clear      = 1'b0;
    vid.tvalid = 1'b0;
    vid.tdata  = '0;
    vid.tlast  = 1'b0;
    vid.tuser  = 1'b0;
    idle(4);

    // Reset values
    chk("rst_tready", 32'(vid.tready), 0);
    chk("rst_err_any", 32'({err_sof_early, err_sof_missing, err_eol_early, err_eol_late, err_data}), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_line_len", 32'(line_len), 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_locked", 32'(locked), 0);
    rst = 1'b0;
    idle(1);
    chk("rx_en_off_tready", 32'(vid.tready), 0);

    // Two clean frames at full throughput
    rx_en = 1'b1;
    idle(1);
    chk("tready_follows", 32'(vid.tready), 1);
    expect_frame(1'b1);
    send_clean_frame(1'b0);
    expect_frame(1'b1);
    send_clean_frame(1'b0);
    idle(3);
    chk("s1_frame_cnt", frame_cnt, 2);
    chk("s1_locked", 32'(locked), 1);
    chk("s1_line_len", 32'(line_len), 8);
    chk("s1_err_cnt", 32'(err_cnt), 0);

    // Clean frames with tready toggling and tvalid gaps
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk);
          #1;
          tog_cnt++;
          if ((tog_cnt % 3) == 0) rx_en = ~rx_en;
        end
      end
      begin
        expect_frame(1'b1);
        send_clean_frame(1'b1);
        expect_frame(1'b1);
        send_clean_frame(1'b1);
        tog_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    idle(3);
    chk("s2_frame_cnt", frame_cnt, 4);
    chk("s2_locked", 32'(locked), 1);
    chk("s2_err_any", 32'({err_sof_early, err_sof_missing, err_eol_early, err_eol_late, err_data}), 0);
    chk("s2_err_cnt", 32'(err_cnt), 0);

    // Early tlast at px=5 of line 1
    expect_frame(1'b0);
    for (int px = 0; px < X; px++) send_pix(px, px == 0, px == X - 1, 32'h0, 1'b0);
    for (int px = 0; px < 6; px++) send_pix(px, 1'b0, px == 5, 32'h0, 1'b0);
    chk("s3_eol_early", 32'(err_eol_early), 1);
    chk("s3_err_cnt", 32'(err_cnt), 1);
    chk("s3_line_len", 32'(line_len), 6);
    chk("s3_locked", 32'(locked), 0);
    for (int ln = 2; ln < Y; ln++)
      for (int px = 0; px < X; px++) send_pix(px, 1'b0, px == X - 1, 32'h0, 1'b0);
    idle(2);
    chk("s3_err_data", 32'(err_data), 0);
    chk("s3_err_cnt_end", 32'(err_cnt), 1);
    do_clear();
    chk("clr_err_any", 32'({err_sof_early, err_sof_missing, err_eol_early, err_eol_late, err_data}), 0);
    chk("clr_err_cnt", 32'(err_cnt), 0);

    // Missing tlast on line 2
    expect_frame(1'b0);
    for (int ln = 0; ln < Y; ln++) begin
      for (int px = 0; px < X; px++) begin
        send_pix(px, (ln == 0) && (px == 0), (px == X - 1) && (ln != 2), 32'h0, 1'b0);
        if ((ln == 2) && (px == X - 1)) begin
          chk("s4_eol_late", 32'(err_eol_late), 1);
          chk("s4_err_cnt", 32'(err_cnt), 1);
        end
      end
    end
    idle(2);
    chk("s4_frame_cnt", frame_cnt, 6);
    do_clear();

    // tuser at px=3 of line 2 restarts the frame
    for (int k = 0; k < 2 * X + 3; k++) send_pix(k % X, k == 0, (k % X) == X - 1, 32'h0, 1'b0);
    expect_frame(1'b1);
    send_pix(0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s5_sof_early", 32'(err_sof_early), 1);
    chk("s5_err_cnt", 32'(err_cnt), 1);
    for (int k = 1; k < X * Y; k++) send_pix(k % X, 1'b0, (k % X) == X - 1, 32'h0, 1'b0);
    idle(2);
    chk("s5_frame_cnt", frame_cnt, 7);
    do_clear();

    // Data corruption, then clear_i coinciding with a new error
    expect_frame(1'b0);
    for (int k = 0; k < X * Y; k++) begin
      if (k == 4) begin
        send_pix(4, 1'b0, 1'b0, 32'h0000_0400, 1'b0);
        chk("s6_err_data", 32'(err_data), 1);
        chk("s6_err_cnt", 32'(err_cnt), 1);
      end else if (k == 6) begin
        send_pix(6, 1'b0, 1'b0, 32'h0000_0400, 1'b1);
        chk("s6_clr_err_data", 32'(err_data), 1);
        chk("s6_clr_err_cnt", 32'(err_cnt), 1);
      end else begin
        send_pix(k % X, k == 0, (k % X) == X - 1, 32'h0, 1'b0);
      end
    end
    idle(2);
    do_clear();

    // Missing SOF after a frame, junk while waiting, then recovery
    send_pix(0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("s7_sof_missing", 32'(err_sof_missing), 1);
    chk("s7_err_cnt", 32'(err_cnt), 1);
    send_pix(2, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
    send_pix(3, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("s7_wait_no_err", 32'({err_eol_early, err_eol_late, err_data}), 0);
    chk("s7_wait_err_cnt", 32'(err_cnt), 1);
    expect_frame(1'b1);
    send_clean_frame(1'b0);
    idle(5);
    chk("final_frame_cnt", frame_cnt, 9);
    chk("final_queue_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the bench never hangs
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
